// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared record layout and commit qualification helper
package commit_trace_pkg;
  localparam int REC_XLEN = 32;
  localparam int REC_SEQ_W = 16;
  typedef struct packed {
    logic [REC_XLEN-1:0]  pc;
    logic [4:0]           rd;
    logic [REC_XLEN-1:0]  data;
    logic [REC_SEQ_W-1:0] seq;
  } commit_rec_t;
  function automatic logic is_qualifying(input logic valid, input logic [4:0] rd, input logic filter);
    return valid && (!filter || rd != 5'd0);
  endfunction
endpackage

// File: rtl/commit_trace_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with count-derived full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // head reads as zero while empty so the outputs are clean after reset
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: qualifies writeback commits, stamps sequence numbers, buffers them
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int SEQ_W     = 16,
  parameter int DROP_W    = 16,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [4:0]                 in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_W-1:0]          drop_cnt
);
  localparam int W = 2*XLEN + 5 + SEQ_W;
  logic [SEQ_W-1:0] seq_next;
  logic qual, push, pop, drop, full, empty;
  logic [W-1:0] dout;
  assign qual      = is_qualifying(in_valid, in_rd, FILTER_X0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = qual && (!full || pop);
  // a flushed commit is discarded, not dropped
  assign drop      = qual && !flush && full && !pop;
  assign {out_pc, out_rd, out_data, out_seq} = dout;
  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .din({in_pc, in_rd, in_data, seq_next}), .dout(dout),
    .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_next <= '0;
      drop_cnt <= '0;
    end else begin
      if (qual) seq_next <= seq_next + 1'b1;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
